// File: rtl/mux_scan.sv
// Registered N-to-1 channel selector with a manual/scan pointer and a
// valid/ready output hold stage (one sample per cycle when the consumer is ready).
module mux_scan #(
   parameter int N       = 8,
   parameter int W       = 1,
   parameter bit REVERSE = 1'b1,
   localparam int SW     = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N*W-1:0]  i,
   input  logic [SW-1:0]   s,
   input  logic            mode,
   input  logic            en,
   input  logic            rdy,
   output logic [W-1:0]    y,
   output logic [SW-1:0]   ch,
   output logic            v,
   output logic            last
);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    y_q, y_d;
   logic [SW-1:0]   ch_q, ch_d;
   logic            last_q, last_d;
   logic [SW-1:0]   c_q, c_d;
   logic [SW-1:0]   p;
   logic [SW-1:0]   idx;
   logic            capture;
   logic [W-1:0]    chan [N];

   for (genvar gi = 0; gi < N; gi++) begin : g_chan
      assign chan[gi] = i[gi*W +: W];
   end

   // N is a power of two, so idx always addresses a real channel.
   assign p   = mode ? c_q : s;
   assign idx = REVERSE ? (SW'(N-1) - p) : p;

   always_comb begin
      state_d = state_q;
      y_d     = y_q;
      ch_d    = ch_q;
      last_d  = last_q;
      c_d     = c_q;
      capture = 1'b0;
      case (state_q)
         IDLE: capture = en;
         HOLD: begin
            if (rdy) begin
               if (en) begin
                  capture = 1'b1;
               end else begin
                  state_d = IDLE;
                  last_d  = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (capture) begin
         state_d = HOLD;
         y_d     = chan[idx];
         ch_d    = p;
         last_d  = mode && (p == SW'(N-1));
         if (mode) c_d = c_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         y_q     <= '0;
         ch_q    <= '0;
         last_q  <= 1'b0;
         c_q     <= '0;
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         ch_q    <= ch_d;
         last_q  <= last_d;
         c_q     <= c_d;
      end
   end

   assign y    = y_q;
   assign ch   = ch_q;
   assign v    = (state_q == HOLD);
   assign last = last_q;

endmodule

// File: tb/tb_mux_scan.sv
// Bench for mux_scan: three configurations driven in parallel, checked against
// a behavioural model plus directed constant expectations.
module tb_mux_scan;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  i1 = '0;
   logic [31:0] i4 = '0;
   logic [2:0]  s = '0;
   logic        mode = 1'b0, en = 1'b0, rdy = 1'b0;

   logic [0:0]  y_a;
   logic [3:0]  y_b, y_c;
   logic [2:0]  ch_a, ch_b, ch_c;
   logic        v_a, v_b, v_c, last_a, last_b, last_c;

   int checks = 0;
   int errors = 0;

   // Model state per instance: 0 = W1/REV1, 1 = W4/REV1, 2 = W4/REV0
   int m_y [3];
   int m_ch [3];
   int m_last [3];
   int m_v [3];
   int m_c [3];

   always #5 clk = ~clk;

   mux_scan #(.N(8), .W(1), .REVERSE(1'b1)) u_a (
      .clk(clk), .rst(rst), .i(i1), .s(s), .mode(mode), .en(en), .rdy(rdy),
      .y(y_a), .ch(ch_a), .v(v_a), .last(last_a));
   mux_scan #(.N(8), .W(4), .REVERSE(1'b1)) u_b (
      .clk(clk), .rst(rst), .i(i4), .s(s), .mode(mode), .en(en), .rdy(rdy),
      .y(y_b), .ch(ch_b), .v(v_b), .last(last_b));
   mux_scan #(.N(8), .W(4), .REVERSE(1'b0)) u_c (
      .clk(clk), .rst(rst), .i(i4), .s(s), .mode(mode), .en(en), .rdy(rdy),
      .y(y_c), .ch(ch_c), .v(v_c), .last(last_c));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < 3; k++) begin
         int p, idx;
         if (rst) begin
            m_y[k] = 0; m_ch[k] = 0; m_last[k] = 0; m_v[k] = 0; m_c[k] = 0;
         end else if (en && (m_v[k] == 0 || rdy)) begin
            p   = mode ? m_c[k] : int'(s);
            idx = (k == 2) ? p : 7 - p;
            if (k == 0) m_y[k] = (int'(i1) >> idx) & 1;
            else        m_y[k] = (int'(i4) >> (idx * 4)) & 15;
            m_ch[k]   = p;
            m_last[k] = (mode && p == 7) ? 1 : 0;
            m_v[k]    = 1;
            if (mode) m_c[k] = (m_c[k] + 1) % 8;
         end else if (m_v[k] == 1 && rdy) begin
            m_v[k] = 0; m_last[k] = 0;
         end
      end
   endtask

   task automatic check_all();
      chk("a_y", 32'(y_a), m_y[0]);   chk("a_ch", 32'(ch_a), m_ch[0]);
      chk("a_v", 32'(v_a), m_v[0]);   chk("a_last", 32'(last_a), m_last[0]);
      chk("b_y", 32'(y_b), m_y[1]);   chk("b_ch", 32'(ch_b), m_ch[1]);
      chk("b_v", 32'(v_b), m_v[1]);   chk("b_last", 32'(last_b), m_last[1]);
      chk("c_y", 32'(y_c), m_y[2]);   chk("c_ch", 32'(ch_c), m_ch[2]);
      chk("c_v", 32'(v_c), m_v[2]);   chk("c_last", 32'(last_c), m_last[2]);
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      check_all();
      $display("t=%0t rst=%0b mode=%0b en=%0b rdy=%0b s=%0d | a y=%0h ch=%0d v=%0b | b y=%0h ch=%0d v=%0b last=%0b | c y=%0h ch=%0d",
               $time, rst, mode, en, rdy, s, y_a, ch_a, v_a, y_b, ch_b, v_b, last_b, y_c, ch_c);
   endtask

   initial begin
      // Reset state
      rst = 1'b1; cyc(); cyc();
      chk("rst_v", 32'(v_b), 0); chk("rst_y", 32'(y_b), 0); chk("rst_ch", 32'(ch_b), 0);

      // Manual mode: single-bit reverse select, then channel 2 on the 4-bit instances
      rst = 1'b0; mode = 1'b0; en = 1'b1; rdy = 1'b1;
      i1 = 8'h80; i4 = 32'h7654_3210; s = 3'd0;
      cyc();
      chk("man_y0", 32'(y_a), 1); chk("man_ch0", 32'(ch_a), 0); chk("man_v0", 32'(v_a), 1);
      s = 3'd7; i1 = 8'h01;
      cyc();
      chk("man_y7", 32'(y_a), 1); chk("man_ch7", 32'(ch_a), 7);
      s = 3'd2;
      cyc();
      chk("fwd_y2", 32'(y_c), 2); chk("fwd_ch2", 32'(ch_c), 2); chk("rev_y2", 32'(y_b), 5);

      // Continuous scan from reset: y = 7..0, ch = 0..7, last on y=0
      rst = 1'b1; cyc();
      rst = 1'b0; mode = 1'b1;
      for (int n = 0; n < 9; n++) begin
         cyc();
         chk("scan_y", 32'(y_b), 7 - (n % 8));
         chk("scan_ch", 32'(ch_b), n % 8);
         chk("scan_last", 32'(last_b), (n % 8 == 7) ? 1 : 0);
      end

      // Stall while ch=2 for three cycles, then resume with ch=3
      cyc(); cyc();
      chk("pre_stall_ch", 32'(ch_b), 2);
      rdy = 1'b0;
      for (int n = 0; n < 3; n++) begin
         s = 3'(n + 4); i4 = 32'hFFFF_FFFF; mode = n[0];
         cyc();
         chk("stall_y", 32'(y_b), 5); chk("stall_ch", 32'(ch_b), 2); chk("stall_v", 32'(v_b), 1);
      end
      i4 = 32'h7654_3210; mode = 1'b1; rdy = 1'b1;
      cyc();
      chk("resume_ch", 32'(ch_b), 3); chk("resume_y", 32'(y_b), 4);

      // Reset mid-HOLD discards sample; first scan capture after it is channel p=0
      rst = 1'b1; rdy = 1'b0;
      cyc();
      chk("midrst_v", 32'(v_b), 0); chk("midrst_ch", 32'(ch_b), 0);
      chk("midrst_y", 32'(y_b), 0); chk("midrst_last", 32'(last_b), 0);
      rst = 1'b0; rdy = 1'b1;
      cyc();
      chk("post_rst_ch", 32'(ch_b), 0); chk("post_rst_y", 32'(y_b), 7);

      // HOLD with en=0, rdy=0 retains; rdy=1 drains to IDLE; scan continues at c=1
      en = 1'b0; rdy = 1'b0;
      cyc(); cyc();
      chk("hold_v", 32'(v_b), 1); chk("hold_y", 32'(y_b), 7);
      rdy = 1'b1;
      cyc();
      chk("drain_v", 32'(v_b), 0);
      cyc();
      chk("idle_v", 32'(v_b), 0); chk("idle_ch", 32'(ch_b), 0);
      en = 1'b1;
      cyc();
      chk("cont_ch", 32'(ch_b), 1); chk("cont_y", 32'(y_b), 6);

      // Randomised traffic checked against the model
      for (int n = 0; n < 400; n++) begin
         rst  = ($urandom_range(0, 31) == 0);
         mode = 1'($urandom);
         en   = ($urandom_range(0, 3) != 0);
         rdy  = ($urandom_range(0, 2) != 0);
         s    = 3'($urandom);
         i1   = 8'($urandom);
         i4   = $urandom;
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mux_scan.md
MUX_SCAN -- requirements
Module: mux_scan

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning channel count; legal values are powers of two from 2 to 64.
REQ-002 The block SHALL have parameter W, default 1, meaning bits per channel.
REQ-003 The block SHALL have parameter REVERSE, default 1, meaning select mapping: 1 = logical select p picks channel N-1-p, 0 = p picks channel p.
REQ-004 The block SHALL derive SW = clog2(N) internally; SW is not user-settable.
REQ-005 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 Port rst  input  1  SHALL be a synchronous, active-high reset.
REQ-007 Port i  input  N*W  SHALL carry the packed channels; channel k occupies bits [k*W+W-1 : k*W].
REQ-008 Port s  input  SW  SHALL be the logical select, used in manual mode.
REQ-009 Port mode  input  1  SHALL select the mode: 0 = manual (select from s), 1 = scan (select from internal counter).
REQ-010 Port en  input  1  SHALL be the capture enable.
REQ-011 Port rdy  input  1  SHALL be the consumer-ready signal.
REQ-012 Port y  output  W  SHALL be the registered selected sample.
REQ-013 Port ch  output  SW  SHALL be the logical select p that produced y.
REQ-014 Port v  output  1  SHALL be the valid flag for y/ch/last.
REQ-015 Port last  output  1  SHALL assert with v when the sample was captured in scan mode with p = N-1.

Function
REQ-016 The block SHALL form the logical pointer p as s when mode=0, and as scan counter c when mode=1.
REQ-017 The block SHALL form physical index idx as N-1-p when REVERSE=1, otherwise as p.
REQ-018 The FSM SHALL have two states: IDLE (v=0) and HOLD (v=1).
REQ-019 A capture SHALL load y<=i[idx], ch<=p, last<=(mode && p==N-1) and v<=1, sampling i, s and mode on the capture edge; latency is 1 cycle.
REQ-020 In IDLE, the block SHALL capture when en=1 and move to HOLD; when en=0 it SHALL stay in IDLE with y, ch and last unchanged.
REQ-021 In HOLD with rdy=0, y, ch, last and v SHALL hold stable regardless of en, s, mode or i.
REQ-022 In HOLD with rdy=1 and en=1, the block SHALL accept the current sample and capture the next one on the same edge (back-to-back, one sample per cycle, no bubble).
REQ-023 In HOLD with rdy=1 and en=0, the block SHALL accept the sample, clear v and last, and enter IDLE.
REQ-024 Deasserting en while in HOLD SHALL NOT drop the pending sample.
REQ-025 rdy in IDLE SHALL be ignored.
REQ-026 Counter c SHALL advance by 1 only on a capture taken with mode=1, and SHALL wrap from N-1 to 0.
REQ-027 Counter c SHALL hold its value during manual mode and during stalls.
REQ-028 A mode change SHALL take effect at the next capture; a scan resumes from the retained c.
REQ-029 Select values are always in range because N is a power of two, so the block SHALL have no out-of-range default path.

Reset
REQ-030 When rst=1 at a clock edge, the block SHALL set y=0, ch=0, v=0, last=0, c=0 and state=IDLE, overriding all other inputs.
REQ-031 Reset mid-HOLD SHALL discard the pending sample without requiring rdy.
REQ-032 The first capture after reset is released SHALL use p=0 in scan mode.

Verification (N=8 unless stated)
REQ-033 The bench SHALL cover: W=1, REVERSE=1, mode=0, i=8'h80, s=0, en=1, rdy=1 -> next cycle y=1, ch=0, v=1; then s=7, i=8'h01 -> y=1, ch=7.
REQ-034 The bench SHALL cover: W=4, REVERSE=1, mode=1, channel k holds value k, en=rdy=1 continuous -> y sequence 7,6,5,4,3,2,1,0,7,...; ch sequence 0..7,0; last=1 only on the y=0 sample.
REQ-035 The bench SHALL cover: scan as in REQ-034 with rdy=0 for 3 cycles while ch=2 -> y=5, ch=2, v=1 stable for all 3 cycles; next accepted capture gives ch=3 with no channel skipped.
REQ-036 The bench SHALL cover: rst=1 for one cycle while ch=3, v=1 -> next cycle y=0, ch=0, v=0, last=0; after release with en=1 the first sample has ch=0, y=7.
REQ-037 The bench SHALL cover: REVERSE=0, W=4, mode=0, s=2, channel k=k -> y=2, ch=2.
REQ-038 The bench SHALL cover: in HOLD, en=0 and rdy=0 for 2 cycles -> sample retained, v=1; then rdy=1 -> next cycle v=0, IDLE, c unchanged.
